// File: rtl/seg7_digit_scanner.sv
// seg7_digit_scanner: frame-synchronous N-digit BCD scan controller; define LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg7_digit_scanner #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [4*N_DIGITS-1:0] value_bcd_i,
    output logic [3:0]            digit_data_o,
    output logic [N_DIGITS-1:0]   digit_en_o,
    output logic                  frame_done_o
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   shd_q, shd_d, disp_q, disp_d;
    logic                    pending_q, pending_d;
    logic                    slot_end, frame_end;
    logic [3:0]              nib;
    assign slot_end     = cnt_q == CW'(REFRESH_DIV - 1);
    assign frame_end    = slot_end && idx_q == IW'(N_DIGITS - 1);
    assign frame_done_o = frame_end;
    assign nib          = disp_q[{idx_q, 2'b00} +: 4];
    assign digit_en_o   = (cnt_q >= CW'(BLANK_CYCLES)) ? {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q : '0;
`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] lz;
    logic                zrun;
    always_comb begin
        lz   = '0;
        zrun = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            zrun  = zrun && disp_q[4*i +: 4] == 4'd0;
            lz[i] = zrun;
        end
    end
    assign digit_data_o = lz[idx_q] ? 4'hF : nib;
`else
    assign digit_data_o = nib;
`endif
    always_comb begin
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = !slot_end ? idx_q : (frame_end ? '0 : idx_q + 1'b1);
        shd_d     = load_i ? value_bcd_i : shd_q;
        pending_d = frame_end ? 1'b0 : (load_i || pending_q);
        // a load landing on the boundary bypasses the shadow so the new frame shows it
        disp_d    = (frame_end && load_i) ? value_bcd_i :
                    (frame_end && pending_q) ? shd_q : disp_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shd_q     <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shd_q     <= shd_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_seg7_digit_scanner.sv
// tb_seg7_digit_scanner: randomized and directed checks against a frame-level reference model.
module tb_seg7_digit_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] value_bcd_i = '0;
    logic [3:0]  digit_data_o;
    logic [3:0]  digit_en_o;
    logic        frame_done_o;
    int          checks = 0;
    int          errors = 0;
    int          t;
    logic [15:0] m_disp, m_shd;
    logic        m_pend;
    seg7_digit_scanner #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .load_i(load_i), .value_bcd_i(value_bcd_i),
        .digit_data_o(digit_data_o), .digit_en_o(digit_en_o), .frame_done_o(frame_done_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
        end
    endtask
    task automatic model_reset();
        t = 0;
        m_disp = '0;
        m_shd = '0;
        m_pend = 1'b0;
    endtask
    task automatic cyc(input logic ld, input logic [15:0] v);
        int dig, pos;
        logic [3:0] exp_d;
        load_i = ld;
        value_bcd_i = v;
        pos = t % 4;
        dig = (t / 4) % 4;
        exp_d = 4'((m_disp >> (4 * dig)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig > 0 && (m_disp >> (4 * dig)) == 16'h0) exp_d = 4'hF;
`endif
        chk("digit_data", 16'(digit_data_o), 16'(exp_d));
        chk("digit_en", 16'(digit_en_o), (pos >= 1) ? 16'(1 << dig) : 16'h0);
        chk("frame_done", 16'(frame_done_o), 16'(t % 16 == 15));
        @(posedge clk);
        if (t % 16 == 15) begin
            if (ld) m_disp = v;
            else if (m_pend) m_disp = m_shd;
            m_pend = 1'b0;
        end else if (ld) m_pend = 1'b1;
        if (ld) m_shd = v;
        t++;
        #1;
        load_i = 1'b0;
    endtask
    task automatic idle_until(input int ph);
        while (t % 16 != ph) cyc(1'b0, 16'h0);
    endtask
    initial begin
        model_reset();
        #2;
        chk("rst_data", 16'(digit_data_o), 16'h0);
        chk("rst_en", 16'(digit_en_o), 16'h0);
        chk("rst_fd", 16'(frame_done_o), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        t = 1;
        repeat (20) cyc(1'b0, 16'h0);
        idle_until(3);
        cyc(1'b1, 16'h1234);
        idle_until(2);
        cyc(1'b1, 16'h1111);
        repeat (3) cyc(1'b0, 16'h0);
        cyc(1'b1, 16'h2222);
        idle_until(15);
        cyc(1'b1, 16'h5678);
        repeat (20) cyc(1'b0, 16'h0);
        idle_until(15);
        cyc(1'b1, 16'h0040);
        repeat (16) cyc(1'b0, 16'h0);
        idle_until(15);
        cyc(1'b1, 16'h0000);
        repeat (16) cyc(1'b0, 16'h0);
        idle_until(15);
        cyc(1'b1, 16'h9000);
        repeat (16) cyc(1'b0, 16'h0);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 7) == 0, 16'($urandom));
        idle_until(15);
        cyc(1'b1, 16'hABCD);
        idle_until(9);
        cyc(1'b1, 16'h4321);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 16'(digit_data_o), 16'h0);
        chk("mid_rst_en", 16'(digit_en_o), 16'h0);
        chk("mid_rst_fd", 16'(frame_done_o), 16'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        t = 1;
        repeat (40) cyc(1'b0, 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
